// File: rtl/score_display_multi_if.sv
// Bundle of the per-player score signals: pixel position in, goal/clear
// controls in, glyph drawing request and score/flag outputs back.
interface score_display_multi_if #(
  parameter int NUM_DIGITS = 2
) ();
  logic [10:0]             offsetX;
  logic [10:0]             offsetY;
  logic                    InsideRectangle;
  logic                    goal_event;
  logic                    score_clear;
  logic                    drawingRequest;
  logic [7:0]              RGBout;
  logic [4*NUM_DIGITS-1:0] score_bcd;
  logic                    scoreLevel1;
  logic                    scoreLevel2;
  logic                    win;

  modport master (
    output offsetX, offsetY, InsideRectangle, goal_event, score_clear,
    input  drawingRequest, RGBout, score_bcd, scoreLevel1, scoreLevel2, win
  );

  modport slave (
    input  offsetX, offsetY, InsideRectangle, goal_event, score_clear,
    output drawingRequest, RGBout, score_bcd, scoreLevel1, scoreLevel2, win
  );
endinterface

// File: rtl/score_display_multi.sv
// BCD goal counter with lockout, level/win flags and a seven-segment style
// 16x32 glyph renderer with leading-zero blanking.
module score_display_multi #(
  parameter int         NUM_DIGITS     = 2,
  parameter int         WIN_SCORE      = 10,
  parameter int         LEVEL1_SCORE   = 3,
  parameter int         LEVEL2_SCORE   = 6,
  parameter int         LOCKOUT_CYCLES = 1000000,
  parameter bit         WRAP           = 1'b0,
  parameter logic [7:0] DIGIT_COLOR    = 8'hFF
) (
  input logic clk,
  input logic reset,
  score_display_multi_if.slave bus
);
  localparam int BW = 14;
  localparam int CW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(LOCKOUT_CYCLES - 1);
  localparam logic [BW-1:0] WIN_B = BW'(WIN_SCORE);
  localparam logic [BW-1:0] LV1_B = BW'(LEVEL1_SCORE);
  localparam logic [BW-1:0] LV2_B = BW'(LEVEL2_SCORE);

  typedef enum logic [1:0] {S_COUNT, S_LOCKOUT, S_WON} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_g_q;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [4*NUM_DIGITS-1:0] r_bcd, w_bcd_nxt, w_inc_bcd;
  logic [BW-1:0]           r_bin, w_bin_nxt, w_inc_bin;
  logic                    r_lvl1, r_lvl2, r_win, r_draw;
  logic                    w_goal, w_carry;

  // Glyph rows built from segments {a,b,c,d,e,f,g}; bit 15 is the leftmost column.
  function automatic logic [15:0] font_row(input logic [3:0] dig, input logic [4:0] row);
    logic [6:0]  seg;
    logic [15:0] r;
    logic        top, mid, bot, up, lo;
    case (dig)
      4'd0: seg = 7'b1111110;
      4'd1: seg = 7'b0110000;
      4'd2: seg = 7'b1101101;
      4'd3: seg = 7'b1111001;
      4'd4: seg = 7'b0110011;
      4'd5: seg = 7'b1011011;
      4'd6: seg = 7'b1011111;
      4'd7: seg = 7'b1110000;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    top = (row >= 5'd2)  && (row <= 5'd4);
    mid = (row >= 5'd14) && (row <= 5'd16);
    bot = (row >= 5'd27) && (row <= 5'd29);
    up  = (row >= 5'd2)  && (row <= 5'd16);
    lo  = (row >= 5'd14) && (row <= 5'd29);
    r = '0;
    if (seg[6] && top) r = r | 16'h3FFC;
    if (seg[5] && up)  r = r | 16'h001C;
    if (seg[4] && lo)  r = r | 16'h001C;
    if (seg[3] && bot) r = r | 16'h3FFC;
    if (seg[2] && lo)  r = r | 16'h3800;
    if (seg[1] && up)  r = r | 16'h3800;
    if (seg[0] && mid) r = r | 16'h3FFC;
    return r;
  endfunction

  assign w_goal = bus.goal_event & ~r_g_q;

  // Ripple BCD increment; carry out of the top digit either wraps or holds at all-9s.
  always_comb begin
    w_inc_bcd = r_bcd;
    w_carry   = 1'b1;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (w_carry) begin
        if (r_bcd[4*d +: 4] == 4'd9) begin
          w_inc_bcd[4*d +: 4] = 4'd0;
        end else begin
          w_inc_bcd[4*d +: 4] = r_bcd[4*d +: 4] + 4'd1;
          w_carry = 1'b0;
        end
      end
    end
    if (w_carry) begin
      w_inc_bcd = WRAP ? '0 : r_bcd;
      w_inc_bin = WRAP ? '0 : r_bin;
    end else begin
      w_inc_bin = r_bin + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bcd_nxt   = r_bcd;
    w_bin_nxt   = r_bin;
    if (bus.score_clear) begin
      w_state_nxt = S_COUNT;
      w_cnt_nxt   = '0;
      w_bcd_nxt   = '0;
      w_bin_nxt   = '0;
    end else begin
      case (r_state)
        S_COUNT: begin
          if (w_goal) begin
            w_bcd_nxt = w_inc_bcd;
            w_bin_nxt = w_inc_bin;
            if ((WIN_SCORE != 0) && (w_inc_bin == WIN_B)) begin
              w_state_nxt = S_WON;
            end else begin
              w_state_nxt = S_LOCKOUT;
              w_cnt_nxt   = LOAD;
            end
          end
        end
        S_LOCKOUT: begin
          if (r_cnt == '0) w_state_nxt = S_COUNT;
          else             w_cnt_nxt   = r_cnt - 1'b1;
        end
        S_WON:   w_state_nxt = S_WON;
        default: w_state_nxt = S_COUNT;
      endcase
    end
  end

  // Renderer: slot 0 is the most significant digit; blanking tracks whether
  // any more significant digit seen so far was nonzero.
  logic [6:0]  w_slot;
  logic [3:0]  w_digit;
  logic        w_blank, w_nz, w_draw_nxt;
  logic [15:0] w_font;

  always_comb begin
    w_slot  = bus.offsetX[10:4];
    w_digit = '0;
    w_blank = 1'b1;
    w_nz    = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      w_nz = w_nz | (r_bcd[4*(NUM_DIGITS-1-i) +: 4] != 4'd0);
      if (w_slot == 7'(i)) begin
        w_digit = r_bcd[4*(NUM_DIGITS-1-i) +: 4];
        w_blank = ~w_nz & (i != NUM_DIGITS - 1);
      end
    end
    w_font     = font_row(w_digit, bus.offsetY[4:0]);
    w_draw_nxt = bus.InsideRectangle & (bus.offsetY[10:5] == '0) &
                 (w_slot < 7'(NUM_DIGITS)) & ~w_blank &
                 w_font[4'd15 - bus.offsetX[3:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_COUNT;
      r_g_q   <= 1'b0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_bin   <= '0;
      r_lvl1  <= 1'b0;
      r_lvl2  <= 1'b0;
      r_win   <= 1'b0;
      r_draw  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_g_q   <= bus.goal_event;
      r_cnt   <= w_cnt_nxt;
      r_bcd   <= w_bcd_nxt;
      r_bin   <= w_bin_nxt;
      r_lvl1  <= ~bus.score_clear & (w_bin_nxt >= LV1_B);
      r_lvl2  <= ~bus.score_clear & (w_bin_nxt >= LV2_B);
      r_win   <= (w_state_nxt == S_WON);
      r_draw  <= w_draw_nxt;
    end
  end

  assign bus.score_bcd      = r_bcd;
  assign bus.scoreLevel1    = r_lvl1;
  assign bus.scoreLevel2    = r_lvl2;
  assign bus.win            = r_win;
  assign bus.drawingRequest = r_draw;
  assign bus.RGBout         = DIGIT_COLOR;
endmodule
